// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver: one-hot select, frame-synchronous double buffer,
// 16-level PWM dimming and an anti-ghosting gap. Define SEG_LZB_EN for leading-zero blanking.
module seven_segment_mux #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DW          = 7,
    parameter int unsigned REFRESH_DIV = 3000,
    parameter int unsigned ACTIVE_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic [3:0]            brightness,
    output logic [DW-1:0]         led_port,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);

    localparam int unsigned SLOT_W  = $clog2(REFRESH_DIV);
    localparam int unsigned DIGIT_W = $clog2(DIGITS);
    localparam int unsigned SEG_W   = (DW < 7) ? DW : 7;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGITS - 1);
    localparam logic               INV        = (ACTIVE_LOW != 0);

    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic [DIGIT_W-1:0]  digit_q, digit_d;
    logic [3:0]          pwm_q, pwm_d;
    logic [4*DIGITS-1:0] pending_q, pending_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic [DW-1:0]       led_q, led_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                frame_done_q, frame_done_d;

    logic                slot_last;
    logic                boundary;
    logic [3:0]          cur_nibble;
    logic                cur_blank;
    logic [DIGITS-1:0]   cur_onehot;
    logic [DIGITS-1:0]   lead_zero;
    logic [6:0]          seg7;
    logic [DW-1:0]       seg_dw;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Slot/digit scan counters and the double-buffered value registers.
    always_comb begin
        slot_last  = (slot_cnt_q == SLOT_LAST);
        boundary   = slot_last && (digit_q == DIGIT_LAST);
        slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (slot_last) begin
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
        end
        pwm_d     = pwm_q + 4'd1;
        pending_d = load ? data : pending_q;
        active_d  = active_q;
        // A load landing in the boundary cycle bypasses pending so it is shown immediately.
        if (boundary) begin
            active_d = load ? data : pending_q;
        end
    end

`ifdef SEG_LZB_EN
    always_comb begin
        logic seen;
        seen      = 1'b0;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            seen         = seen | (active_q[4*i +: 4] != 4'h0);
            lead_zero[i] = ~seen;
        end
    end
`else
    assign lead_zero = '0;
`endif

    always_comb begin
        cur_nibble = 4'h0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_q == DIGIT_W'(i)) begin
                cur_nibble    = active_q[4*i +: 4];
                cur_blank     = lead_zero[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        seg7                = hex_to_seg(cur_nibble);
        seg_dw              = '0;
        seg_dw[SEG_W-1:0]   = seg7[SEG_W-1:0];
        led_d               = cur_blank ? '0 : seg_dw;
        // slot_cnt == 0 keeps every digit dark so segments settle before the next select.
        sel_d               = ((slot_cnt_q != '0) && (pwm_q <= brightness)) ? cur_onehot : '0;
        frame_done_d        = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q   <= '0;
            digit_q      <= '0;
            pwm_q        <= 4'd0;
            pending_q    <= '0;
            active_q     <= '0;
            led_q        <= {DW{INV}};
            sel_q        <= {DIGITS{INV}};
            frame_done_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_q      <= digit_d;
            pwm_q        <= pwm_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            led_q        <= led_d ^ {DW{INV}};
            sel_q        <= sel_d ^ {DIGITS{INV}};
            frame_done_q <= frame_done_d;
        end
    end

    assign led_port   = led_q;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Self-checking bench for seven_segment_mux: directed scenarios plus randomized loads and
// brightness, compared against a cycle-count based reference model.
module tb_seven_segment_mux;

    localparam int D  = 4;
    localparam int RD = 4;
    localparam int F  = D * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] data;
    logic [3:0]  brightness;
    logic [6:0]  led_port;
    logic [3:0]  sel;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seven_segment_mux #(
        .DIGITS      (D),
        .DW          (7),
        .REFRESH_DIV (RD),
        .ACTIVE_LOW  (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .load       (load),
        .brightness (brightness),
        .led_port   (led_port),
        .sel        (sel),
        .frame_done (frame_done)
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: t counts clock edges since reset; everything else follows from it.
    int          t;
    logic [15:0] m_active, m_pending;
    logic [6:0]  e_led;
    logic [3:0]  e_sel;
    logic        e_fd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("led_port", 32'(led_port), 32'(e_led));
        check_eq("sel", 32'(sel), 32'(e_sel));
        check_eq("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic model_reset();
        t         = 0;
        m_active  = 16'h0;
        m_pending = 16'h0;
        e_led     = 7'h00;
        e_sel     = 4'h0;
        e_fd      = 1'b0;
    endtask

    // Called at a negedge: check, drive, predict the next edge, advance to next negedge.
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] br);
        int         slot, dig;
        logic [3:0] nib;
        logic       blank;
        check_outputs();
        load       = ld;
        data       = d;
        brightness = br;
        slot  = t % RD;
        dig   = (t / RD) % D;
        nib   = 4'(m_active >> (4 * dig));
        blank = 1'b0;
`ifdef SEG_LZB_EN
        if (dig > 0 && (m_active >> (4 * dig)) == 16'h0) blank = 1'b1;
`endif
        e_led = blank ? 7'h00 : seg_tab[nib];
        e_sel = (slot != 0 && (t % 16) <= int'(br)) ? 4'(1 << dig) : 4'h0;
        e_fd  = (t % F == F - 1);
        if (t % F == F - 1) m_active = ld ? d : m_pending;
        if (ld) m_pending = d;
        t++;
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        data       = 16'h0;
        brightness = 4'd15;
        repeat (2) @(negedge clk);
        model_reset();
        check_outputs();
        reset = 1'b0;

        repeat (2 * F) step(1'b0, 16'h0, 4'd15);

        // Mid-frame load keeps the current frame intact.
        repeat (5) step(1'b0, 16'h0, 4'd15);
        step(1'b1, 16'h12AF, 4'd15);
        repeat (2 * F) step(1'b0, 16'h0, 4'd15);

        // Load in the boundary cycle is displayed on the very next slot.
        while (t % F != F - 1) step(1'b0, 16'h0, 4'd15);
        step(1'b1, 16'h0008, 4'd15);
        repeat (F) step(1'b0, 16'h0, 4'd15);

        step(1'b1, 16'h0040, 4'd15);
        repeat (2 * F) step(1'b0, 16'h0, 4'd15);
        step(1'b1, 16'h0000, 4'd15);
        repeat (2 * F) step(1'b0, 16'h0, 4'd15);

        // Dimming sweep, including the dimmest level.
        for (int b = 0; b < 16; b += 5) begin
            repeat (2 * F) step(1'b0, 16'h0, 4'(b));
        end

        repeat (600) begin
            step($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-slot discards a pending load.
        step(1'b1, 16'hFFFF, 4'd15);
        while (t % RD != 2 || t % F == F - 1) step(1'b0, 16'h0, 4'd15);
        check_outputs();
        reset = 1'b1;
        #1;
        check_eq("async_led", 32'(led_port), 32'h0);
        check_eq("async_sel", 32'(sel), 32'h0);
        check_eq("async_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        repeat (2 * F) step(1'b0, 16'h0, 4'd15);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Parametrised multiplexed driver for a row of DIGITS common-cathode or common-anode seven-segment digits. It generalises the two-digit hex decoder. Features:
- N digits, time-multiplexed with a one-hot digit select.
- Frame-synchronous double-buffered value updates.
- 16-level brightness PWM.
- Anti-ghosting select gap.
- Optional leading-zero blanking.

It sits between the user logic holding a hex value and the board's segment/select pins.

## Interface
- DIGITS, 4: number of digits; 2..8.
- DW, 7: segment bus width; bit0=a … bit6=g.
- REFRESH_DIV, 3000: clock cycles per digit slot; ≥2 (3000 at 12 MHz gives a 1 kHz frame for 4 digits).
- ACTIVE_LOW, 0: 1 inverts both led_port and sel at the output register.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- data  input  4*DIGITS  hex value; nibble i drives digit i; digit 0 is the rightmost, least significant.
- load  input  1  one-cycle strobe; captures data.
- brightness  input  4  0 = dimmest (1/16 duty), 15 = full.
- led_port  output  DW  segment drive; registered.
- sel  output  DIGITS  one-hot digit enable; registered.
- frame_done  output  1  one-cycle pulse per completed frame; registered.

## Operation
- Internal state:
  - slot_cnt: 0..REFRESH_DIV-1.
  - digit: 0..DIGITS-1.
  - pwm: 4-bit free-running counter.
  - pending and active: 4*DIGITS-bit value registers.
- slot_cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and digit increments. digit wraps from DIGITS-1 to 0.
- Frame boundary: the cycle with digit==DIGITS-1 and slot_cnt==REFRESH_DIV-1.
- On load=1, pending <= data. Multiple loads within a frame: the last one wins.
- At the frame boundary edge, active <= pending. If load=1 in the boundary cycle, active <= data directly.
- Only active is displayed, so the displayed value never changes mid-frame.
- Decode, active-high values: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- sel bit `digit` is asserted when slot_cnt≠0 and pwm≤brightness; otherwise all sel bits are inactive. slot_cnt=0 is the anti-ghosting gap.
- frame_done is asserted the cycle after the frame boundary.
- A brightness change takes effect on the next pwm comparison; there is no frame synchronisation.

## Timing
- Reset, asynchronous:
  - slot_cnt, digit, pwm, pending and active are 0.
  - led_port is 0 (all ones if ACTIVE_LOW).
  - sel is all inactive.
  - frame_done is 0.
- Output latency: led_port, sel and frame_done reflect the internal state of the previous cycle (1-cycle register stage).
- First post-reset frame: digit 0 displays "0" from cycle 1 onward.
- load-to-display latency: until the next frame boundary. Worst case is DIGITS*REFRESH_DIV cycles; best case, with load in the boundary cycle, is 1 cycle.
- Reset asserted mid-frame: all outputs go to their reset values immediately. A pending load is discarded.
- frame_done period is exactly DIGITS*REFRESH_DIV cycles.

## Configuration
- SEG_LZB_EN defined: digit i (i≥1) has led_port forced to blank when nibbles i..DIGITS-1 of active are all zero.
  - sel timing is unchanged.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- SEG_LZB_EN undefined: all digits always show their decoded nibble, including leading zeros.

## Test plan
Use DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0, brightness=15 unless stated.
- Reset held, then released with no load → led_port=00 during reset. After release, 3F on every slot; sel cycles 0001,0010,0100,1000. frame_done pulses every 16 cycles.
- load data=16'h12AF mid-frame → the current frame still shows 0000. From the next frame: digit0=71, digit1=77, digit2=5B, digit3=06.
- load in the frame-boundary cycle with data=16'h0008 → the immediately following digit-0 slot shows 7F.
- brightness=0, REFRESH_DIV=64 → within each slot, sel is active only where pwm==0 and slot_cnt≠0. The slot_cnt=0 cycle always has sel=0000.
- SEG_LZB_EN defined, load 16'h0040 → digit3 and digit2 led_port=00; digit1=66; digit0=3F. Load 16'h0000 → only digit0 shows 3F.
- Assert reset for 1 cycle mid-slot after loading 16'hFFFF → outputs return to reset values at once. The next frame shows 3F on all digits (pending cleared).
